// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - UART receiver line and byte-output bundle
// master: the receiver (drives bytes/strobes); slave: line driver and byte consumer.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output rx_byte,
    output received,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_byte,
    input  received,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with stop-bit error flag
// Samples each bit once at its centre; a bad stop bit parks in WAIT_IDLE until the line recovers.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             received_q, received_d;
  logic             frame_err_q, frame_err_d;
  logic             rxs;

  assign sync1_d = bus.rx;
  assign sync2_d = sync1_q;
  assign rxs     = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      received_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      received_q  <= received_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    received_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
        end
      end

      // A start bit must still be low at its centre, otherwise it was a glitch.
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at the stop-bit centre gives half a bit of slack for the next start edge.
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rx_byte   = rx_byte_q;
  assign bus.received  = received_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
